// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin computed DIGIT bits per clock with valid/ready on both sides.
// Optional subtract mode and signed-overflow flag are enabled by defining DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    count;
  logic             sub_i;
  logic [DIGIT:0]   slice;
  logic [WIDTH+DIGIT-1:0] sum_cat;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // The single DIGIT-wide adder slice; b_q already holds the (possibly inverted) operand.
  assign slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // Concatenation keeps the shift legal even when DIGIT == WIDTH.
  assign sum_cat = {slice[DIGIT-1:0], sum};

  // NOTE: every register here is assigned with <= so all state updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub_i}};
            carry    <= cin ^ sub_i;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          carry <= slice[DIGIT];
          count <= count + CW'(1);
          if (count == CW'(NDIG - 1)) begin
            cout      <= slice[DIGIT];
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
            // Carry into the MSB is recovered from the MSB's own sum bit.
            ovf       <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: an 8-bit/2-bit-digit instance and an 8-bit/8-bit-digit instance.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv, ir, ov, ordy, ci, co, bz, sb, of;
  logic [7:0] a, b, s;
  logic       iv1, ir1, ov1, ordy1, ci1, co1, bz1, sb1, of1;
  logic [7:0] a1, b1, s1;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sb), .ovf(of),
`endif
    .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .busy(bz)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sb1), .ovf(of1),
`endif
    .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(co1), .busy(bz1)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  res_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sub);
    logic [7:0] ye;
    logic [8:0] t;
    res_t r;
    ye    = y ^ {8{sub}};
    t     = {1'b0, x} + {1'b0, ye} + {8'd0, c ^ sub};
    r.sum  = t[7:0];
    r.cout = t[8];
    r.ovf  = (x[7] == ye[7]) && (t[7] != x[7]);
    return r;
  endfunction

  // Waits (bounded) for in_ready, presents operands for one accepting edge, returns at edge+#1.
  task automatic accept8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sub);
    int n = 0;
    @(negedge clk);
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir) check("accept_timeout", 32'(ir), 32'd1);
    iv = 1'b1; a = x; b = y; ci = c; sb = sub;
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sub,
                     input int hold, input bit noise);
    res_t exp;
    accept8(x, y, c, sub);
    sb_q.push_back(model(x, y, c, sub));
    for (int i = 0; i < 4; i++) begin
      check("run_busy", 32'(bz), 32'd1);
      check("run_in_ready", 32'(ir), 32'd0);
      if (noise) begin
        iv = 1'b1; a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    check("done_out_valid", 32'(ov), 32'd1);
    check("done_busy", 32'(bz), 32'd0);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    exp = sb_q.pop_front();
    for (int j = 0; j < hold; j++) begin
      check("hold_out_valid", 32'(ov), 32'd1);
      check("hold_in_ready", 32'(ir), 32'd0);
      check("hold_sum", 32'(s), 32'(exp.sum));
      check("hold_cout", 32'(co), 32'(exp.cout));
      if (noise) begin
        iv = 1'b1; a = 8'($urandom); b = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    iv = 1'b0;
    check("sum", 32'(s), 32'(exp.sum));
    check("cout", 32'(co), 32'(exp.cout));
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    check("ovf", 32'(of), 32'(exp.ovf));
`endif
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("post_out_valid", 32'(ov), 32'd0);
    check("post_in_ready", 32'(ir), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t e1;
    rst = 1'b1;
    iv = 0; ordy = 0; a = 0; b = 0; ci = 0; sb = 0;
    iv1 = 0; ordy1 = 0; a1 = 0; b1 = 0; ci1 = 0; sb1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 32'(ir), 32'd1);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_busy", 32'(bz), 32'd0);
    check("rst_sum", 32'(s), 32'd0);
    check("rst_cout", 32'(co), 32'd0);
    check("rst_d8_in_ready", 32'(ir1), 32'd1);
    check("rst_d8_out_valid", 32'(ov1), 32'd0);

    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
    op8(8'hFF, 8'h01, 1'b1, 1'b0, 5, 1'b0);

    // Abort two cycles into RUN; nothing is pushed to the scoreboard for it.
    accept8(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(ov), 32'd0);
    check("abort_sum", 32'(s), 32'd0);
    check("abort_in_ready", 32'(ir), 32'd1);
    check("abort_busy", 32'(bz), 32'd0);

    op8(8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);
    op8(8'hA5, 8'hC3, 1'b1, 1'b0, 3, 1'b1);
    for (int k = 0; k < 4; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, k, 1'b1);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
`endif

    // Single-digit instance: result one cycle after the accepting edge.
    @(negedge clk);
    check("d8_in_ready", 32'(ir1), 32'd1);
    iv1 = 1'b1; a1 = 8'h80; b1 = 8'h80; ci1 = 1'b0; sb1 = 1'b0;
    sb_q.push_back(model(8'h80, 8'h80, 1'b0, 1'b0));
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = 8'h11; b1 = 8'h22;
    check("d8_busy", 32'(bz1), 32'd1);
    check("d8_early_out_valid", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    check("d8_out_valid", 32'(ov1), 32'd1);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e1 = sb_q.pop_front();
      check("d8_sum", 32'(s1), 32'(e1.sum));
      check("d8_cout", 32'(co1), 32'(e1.cout));
    end
    ordy1 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0;
    check("d8_post_in_ready", 32'(ir1), 32'd1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Multi-cycle, digit-serial binary adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using one DIGIT-wide adder slice.
- Area-reduced successor to the single-bit gate-level full adder used in generic RTL netlists, with a valid/ready handshake on both input and output.
- Sits between an operand producer and a result consumer in datapath netlists.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be ≥ 1 and a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle. Must be ≥ 1. NDIG = WIDTH/DIGIT digit steps.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b/cin are presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high while in RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: on rst=1 at a clock edge, the FSM goes to IDLE and the digit counter clears. Outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Reset mid-RUN or mid-DONE aborts the operation and the result is discarded.
- IDLE: in_ready=1.
  - in_valid=1 at an edge captures a, b, cin into shift registers, sets carry=cin and count=0, and moves to RUN.
- RUN: in_ready=0, busy=1.
  - Each cycle adds the low DIGIT bits of the A and B registers plus carry.
  - The DIGIT-bit result shifts into the MSB end of the sum register. Both operand registers shift right by DIGIT. Carry updates. count increments.
  - At count=NDIG-1, the final digit completes and the FSM moves to DONE.
  - RUN lasts exactly NDIG cycles. out_valid rises NDIG cycles after the accepting edge.
  - DIGIT=WIDTH gives a 1-cycle RUN.
- DONE: out_valid=1, busy=0, in_ready=0.
  - sum and cout are held stable until the handshake completes.
  - out_valid & out_ready at an edge moves to IDLE.
  - in_valid is ignored in DONE; there is no overlap or accept-on-same-edge.
- Back-to-back throughput: one result per NDIG+2 cycles minimum (accept edge, NDIG RUN cycles, DONE handshake edge).
- in_valid is ignored unless in IDLE. Inputs are sampled only at the accept edge, so later changes to a/b/cin do not affect the result.
- Wrap-around: the sum is modulo 2^WIDTH. Carry beyond bit WIDTH-1 appears only on cout.
- sum and cout are registered outputs. They show intermediate shift contents while busy=1 and are valid only when out_valid=1.

Optional Feature:
- Macro DIGIT_SERIAL_ADDER_SUB_EN.
- Defined: adds an input port sub (1 bit), captured with the operands.
  - Effective operation is a + (b XOR {WIDTH{sub}}) + (cin XOR sub).
  - With sub=1 and cin=0 the result is a − b. cout=1 means no borrow.
  - Adds output port ovf (1 bit, reset 0), valid with out_valid. It is the signed overflow, computed as the carry into the MSB XOR cout.
- Undefined: no sub or ovf ports; the block is add-only.

Test Plan:
- WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, cin=0 accepted at edge T → busy for 4 cycles, out_valid at T+4 with sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=1, out_ready held 0 for 5 cycles → sum=0x01, cout=1. Both held stable, out_valid held, in_ready=0 until out_ready=1. Then IDLE and in_ready=1 the next cycle.
- Assert rst for one edge 2 cycles into RUN of a=0x12, b=0x34 → next cycle out_valid=0, sum=0, in_ready=1. A following op a=0x01, b=0x02 gives sum=0x03.
- Toggle in_valid and change a/b during RUN and DONE → no extra acceptance; the result matches the originally captured operands.
- WIDTH=8, DIGIT=8 → out_valid 1 cycle after accept. a=0x80, b=0x80 → sum=0x00, cout=1.
- With DIGIT_SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
